// File: rtl/rsa_crt_decrypt.sv
// RSA-CRT decryption: two half-width LSB-first modular exponentiations, then Garner recombination.
// Optional build macro RSA_PARAM_CHECK_EN rejects degenerate p/q with a fast error result.
module rsa_crt_decrypt #(
  parameter  int WIDTH = 512,
  localparam int HALF  = WIDTH / 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] ciphertext,
  input  logic [HALF-1:0]  p,
  input  logic [HALF-1:0]  q,
  input  logic [HALF-1:0]  dp,
  input  logic [HALF-1:0]  dq,
  input  logic [HALF-1:0]  qinv,
  input  logic             valid_in,
  output logic [WIDTH-1:0] m_out,
  output logic             valid_out,
  output logic             busy_out,
  output logic             error_out
);

  localparam int IW = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, EXP_P, EXP_Q, SUB, MUL, ADD, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  c_r;
  logic [HALF-1:0]   p_r, q_r, dp_r, dq_r, qinv_r;
  logic [HALF-1:0]   base, acc, m1, m2, t, h;
  logic [IW-1:0]     idx;
  logic [HALF-1:0]   md, base_sq, acc_next;
  logic              exp_bit, idx_last;

  function automatic logic [2*HALF-1:0] zx(input logic [HALF-1:0] a);
    return {{HALF{1'b0}}, a};
  endfunction

  function automatic logic [2*HALF-1:0] mul(input logic [HALF-1:0] a, input logic [HALF-1:0] b);
    return zx(a) * zx(b);
  endfunction

  // Remainder is always below m, so only the low half carries information.
  function automatic logic [HALF-1:0] mod_h(input logic [2*HALF-1:0] x, input logic [HALF-1:0] m);
    logic [2*HALF-1:0] r;
    r = x % zx(m);
    return r[HALF-1:0];
  endfunction

  // One square-and-multiply step, shared by both half exponentiations.
  assign md       = (state == EXP_Q) ? q_r : p_r;
  assign exp_bit  = (state == EXP_Q) ? dq_r[idx] : dp_r[idx];
  assign base_sq  = mod_h(mul(base, base), md);
  assign acc_next = exp_bit ? mod_h(mul(acc, base), md) : acc;
  assign idx_last = (idx == IW'(HALF - 1));

`ifdef RSA_PARAM_CHECK_EN
  logic param_bad;
  logic err_r;
  assign param_bad = (p < HALF'(2)) || (q < HALF'(2)) || (p == q);
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt; otherwise a latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: if (valid_in) begin
`ifdef RSA_PARAM_CHECK_EN
        state_nxt = param_bad ? DONE : LOAD;
`else
        state_nxt = LOAD;
`endif
      end
      LOAD:    state_nxt = EXP_P;
      EXP_P:   if (idx_last) state_nxt = EXP_Q;
      EXP_Q:   if (idx_last) state_nxt = SUB;
      SUB:     state_nxt = MUL;
      MUL:     state_nxt = ADD;
      ADD:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_out = (state == DONE);
    busy_out  = (state != IDLE);
`ifdef RSA_PARAM_CHECK_EN
    error_out = (state == DONE) && err_r;
`else
    error_out = 1'b0;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: datapath registers are cleared on reset too, so an aborted job leaves nothing behind.
    if (!rst_in) begin
      c_r    <= '0;
      p_r    <= '0;
      q_r    <= '0;
      dp_r   <= '0;
      dq_r   <= '0;
      qinv_r <= '0;
      base   <= '0;
      acc    <= '0;
      m1     <= '0;
      m2     <= '0;
      t      <= '0;
      h      <= '0;
      idx    <= '0;
      m_out  <= '0;
`ifdef RSA_PARAM_CHECK_EN
      err_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          c_r    <= ciphertext;
          p_r    <= p;
          q_r    <= q;
          dp_r   <= dp;
          dq_r   <= dq;
          qinv_r <= qinv;
`ifdef RSA_PARAM_CHECK_EN
          err_r  <= param_bad;
          if (param_bad) m_out <= '0;
`endif
        end
        LOAD: begin
          base <= mod_h(c_r, p_r);
          acc  <= mod_h(zx(HALF'(1)), p_r);
          idx  <= '0;
        end
        EXP_P, EXP_Q: begin
          acc  <= acc_next;
          base <= base_sq;
          idx  <= idx + IW'(1);
          if (idx_last) begin
            idx <= '0;
            if (state == EXP_P) begin
              // Hand over to the mod-q exponentiation without an extra load cycle.
              m1   <= acc_next;
              base <= mod_h(c_r, q_r);
              acc  <= mod_h(zx(HALF'(1)), q_r);
            end else begin
              m2 <= acc_next;
            end
          end
        end
        // m2 is reduced mod p first because q may exceed p.
        SUB:     t     <= mod_h(zx(m1) + zx(p_r) - zx(mod_h(zx(m2), p_r)), p_r);
        MUL:     h     <= mod_h(mul(qinv_r, t), p_r);
        ADD:     m_out <= zx(m2) + mul(h, q_r);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_crt_decrypt.sv
// Scoreboard bench for rsa_crt_decrypt at WIDTH=16 with the textbook key p=61, q=53.
// Latency is counted inclusively: accept cycle is 1, the valid_out cycle is 2*HALF+6.
module tb_rsa_crt_decrypt;

  localparam int WIDTH = 16;
  localparam int HALF  = WIDTH / 2;
  localparam int LAT   = 2 * HALF + 6;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [WIDTH-1:0] ciphertext;
  logic [HALF-1:0]  p, q, dp, dq, qinv;
  logic             valid_in;
  logic [WIDTH-1:0] m_out;
  logic             valid_out, busy_out, error_out;

  typedef struct {
    logic [WIDTH-1:0] m;
    logic             err;
    int               lat;
    bit               chk_m;
    int               acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   prev_valid = 1'b0;

  rsa_crt_decrypt #(.WIDTH(WIDTH)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .ciphertext(ciphertext),
    .p         (p),
    .q         (q),
    .dp        (dp),
    .dq        (dq),
    .qinv      (qinv),
    .valid_in  (valid_in),
    .m_out     (m_out),
    .valid_out (valid_out),
    .busy_out  (busy_out),
    .error_out (error_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result strobe consumes one scoreboard entry.
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (prev_valid) check("valid_one_cycle", valid_out, 0);
      if (valid_out) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid_out=1, expected no pending job");
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.chk_m) check("m_out", m_out, mon_e.m);
          check("error_out", error_out, mon_e.err);
          check("latency", cyc - mon_e.acc_cyc + 1, mon_e.lat);
        end
      end
      prev_valid = valid_out;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] m_exp, input logic err_exp,
                          input int lat_exp, input bit chk_m);
    exp_t e;
    e.m       = m_exp;
    e.err     = err_exp;
    e.lat     = lat_exp;
    e.chk_m   = chk_m;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int b = 0;
    @(negedge clk_in);
    while (busy_out && b < 100) begin
      @(negedge clk_in);
      b++;
    end
    check("idle_before_issue", busy_out, 0);
  endtask

  task automatic issue(input logic [WIDTH-1:0] c, input logic [HALF-1:0] pp,
                       input logic [WIDTH-1:0] m_exp, input logic err_exp,
                       input int lat_exp, input bit chk_m);
    wait_idle();
    ciphertext = c;
    p          = pp;
    valid_in   = 1'b1;
    push_exp(m_exp, err_exp, lat_exp, chk_m);
    @(negedge clk_in);
    valid_in = 1'b0;
    check("busy_after_accept", busy_out, 1);
  endtask

  task automatic drain();
    int b = 0;
    while (sb_q.size() != 0 && b < 200) begin
      @(negedge clk_in);
      b++;
    end
    check("drain_pending", sb_q.size(), 0);
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    rst_in     = 1'b0;
    valid_in   = 1'b0;
    ciphertext = '0;
    p          = 8'd61;
    q          = 8'd53;
    dp         = 8'd53;
    dq         = 8'd49;
    qinv       = 8'd38;
    repeat (2) @(negedge clk_in);
    check("reset_m_out", m_out, 0);
    check("reset_valid_out", valid_out, 0);
    check("reset_busy_out", busy_out, 0);
    check("reset_error_out", error_out, 0);
    rst_in = 1'b1;

    // Back-to-back jobs, each issued the cycle after the previous DONE.
    issue(16'd2790, 8'd61, 16'd65,  1'b0, LAT, 1'b1);
    issue(16'd855,  8'd61, 16'd123, 1'b0, LAT, 1'b1);
    issue(16'd0,    8'd61, 16'd0,   1'b0, LAT, 1'b1);
    issue(16'd1,    8'd61, 16'd1,   1'b0, LAT, 1'b1);
    drain();

    // valid_in held through EXP_P with the ciphertext changed: only the first accept counts.
    wait_idle();
    ciphertext = 16'd2790;
    valid_in   = 1'b1;
    push_exp(16'd65, 1'b0, LAT, 1'b1);
    repeat (5) @(negedge clk_in);
    ciphertext = 16'd855;
    repeat (6) @(negedge clk_in);
    valid_in = 1'b0;
    drain();

    // Asynchronous reset during EXP_Q, asserted between clock edges.
    issue(16'd2790, 8'd61, 16'd65, 1'b0, LAT, 1'b1);
    repeat (12) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    check("abort_m_out", m_out, 0);
    check("abort_valid_out", valid_out, 0);
    check("abort_busy_out", busy_out, 0);
    sb_q.delete();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    issue(16'd2790, 8'd61, 16'd65, 1'b0, LAT, 1'b1);
    drain();

    // Degenerate p=1.
`ifdef RSA_PARAM_CHECK_EN
    issue(16'd2790, 8'd1, 16'd0, 1'b1, 2, 1'b1);
`else
    issue(16'd2790, 8'd1, 16'd0, 1'b0, LAT, 1'b0);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no summary by 100000 time units, expected completion");
    $fatal(1, "timeout");
  end

endmodule
